// File: rtl/memaccess_engine_pkg.sv
// memaccess_engine_pkg
//   Shared types for the memory-access engine: the request opcode encoding,
//   the control FSM states, the externally visible mem_state codes, and small
//   helpers that decode an opcode into its "indirect" and "write" properties.
package memaccess_engine_pkg;

  // Request opcodes as presented on req_op.
  typedef enum logic [1:0] {
    OP_READ      = 2'b00,
    OP_READ_IND  = 2'b01,
    OP_WRITE     = 2'b10,
    OP_WRITE_IND = 2'b11
  } op_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IND  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // mem_state output encodings.
  localparam logic [1:0] MS_READ  = 2'b00;
  localparam logic [1:0] MS_WRITE = 2'b01;
  localparam logic [1:0] MS_IND   = 2'b10;
  localparam logic [1:0] MS_IDLE  = 2'b11;

  // Bit 1 of the opcode selects a store, bit 0 selects indirect addressing.
  function automatic logic op_is_write(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_ind(input op_e op);
    return op[0];
  endfunction

  // IDLE and RESP both report as idle on mem_state.
  function automatic logic [1:0] mem_state_of(input state_e st);
    logic [1:0] ms;
    case (st)
      ST_RD:   ms = MS_READ;
      ST_WR:   ms = MS_WRITE;
      ST_IND:  ms = MS_IND;
      default: ms = MS_IDLE;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/memaccess_engine_timeout_ctr.sv
// memaccess_timeout_ctr
//   Per-access wait counter. It is cleared on entry to each access state and
//   counts cycles without an ack. expired is high while the count equals
//   TIMEOUT; the count then holds so expired stays asserted until cleared.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   clr     synchronous clear (entering an access state)
//   en      count enable (in an access state, no ack this cycle)
//   expired count has reached TIMEOUT
module memaccess_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = (count_q == CW'(TIMEOUT));

  // Clear has priority; counting stops once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memaccess_engine.sv
// memaccess_engine
//   Executes one load/store request at a time against a handshake data memory.
//   Indirect ops first read a pointer (IND), then perform the real access at
//   the pointer address. Each access waits for dmem_ack, bounded by a TIMEOUT
//   wait counter; a timeout aborts the whole op and reports resp_err.
//   All outputs come from registers or from decoding the state register.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   req_valid/req_op/req_addr/req_data, req_ready   request handshake
//   resp_valid/resp_data/resp_err                   one-cycle completion
//   mem_state                    current access kind (00 rd, 01 wr, 10 ind, 11 idle)
//   dmem_en/we/addr/din, dmem_dout/ack              data memory port
module memaccess_engine #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic [1:0]    mem_state,
  output logic          dmem_en,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_din,
  input  logic [DW-1:0] dmem_dout,
  input  logic          dmem_ack
);

  import memaccess_engine_pkg::*;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic in_access;
  logic ctr_clr;
  logic ctr_en;
  logic expired;

  assign in_access = (state_q == ST_IND) || (state_q == ST_RD) || (state_q == ST_WR);

  // Decoded outputs; dmem_ack only matters while an access is in flight.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = err_q;
  assign resp_data  = rdata_q;
  assign mem_state  = mem_state_of(state_q);
  assign dmem_en    = in_access;
  assign dmem_we    = (state_q == ST_WR);
  assign dmem_addr  = addr_q;
  assign dmem_din   = din_q;

  // Next-state logic. An ack is checked before the timeout so that an ack in
  // the expiring cycle still completes normally.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = op_e'(req_op);
          addr_d = req_addr;
          din_d  = req_data;
          if (op_is_ind(op_e'(req_op))) begin
            state_d = ST_IND;
          end else if (op_is_write(op_e'(req_op))) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_IND: begin
        if (dmem_ack) begin
          addr_d  = dmem_dout[AW-1:0];
          state_d = op_is_write(op_q) ? ST_WR : ST_RD;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RD: begin
        if (dmem_ack) begin
          rdata_d = dmem_dout;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        if (dmem_ack) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // The counter restarts whenever a new access state is entered (including
  // IND -> RD/WR), and counts only cycles that end without an ack.
  always_comb begin
    ctr_clr = (state_d != state_q) &&
              ((state_d == ST_IND) || (state_d == ST_RD) || (state_d == ST_WR));
    ctr_en  = in_access && !dmem_ack;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  memaccess_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset  (reset),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expired(expired)
  );

endmodule

// File: tb/tb_memaccess_engine.sv
// tb_memaccess_engine
//   Directed bench for memaccess_engine. Requests are issued from one linear
//   initial block; the expected response (data, error flag, latency) is queued
//   when a request is issued and popped when resp_valid appears. The memory
//   side is played in-line, checking the access strobes/address/data every
//   cycle an access is expected.
module tb_memaccess_engine;

  import memaccess_engine_pkg::*;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [1:0]  mem_state;
  logic        dmem_en;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;
  logic        dmem_ack;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } sb_t;

  sb_t sbQ[$];
  int  checks;
  int  failures;
  int  cyc;
  int  acceptCyc;

  memaccess_engine #(
    .AW(16),
    .DW(16),
    .TIMEOUT(15)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .mem_state (mem_state),
    .dmem_en   (dmem_en),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_dout (dmem_dout),
    .dmem_ack  (dmem_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic stepCycle();
    @(negedge clock);
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_resp_data"}, resp_data, 0);
    checkOutput({tag, "_mem_state"}, mem_state, MS_IDLE);
    checkOutput({tag, "_dmem_en"}, dmem_en, 0);
    checkOutput({tag, "_dmem_we"}, dmem_we, 0);
    checkOutput({tag, "_dmem_addr"}, dmem_addr, 0);
    checkOutput({tag, "_dmem_din"}, dmem_din, 0);
  endtask

  // Presents one request for the accepting edge and queues its expectation.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr,
                               input logic [15:0] data, input logic [15:0] expData,
                               input logic expErr, input int expLat,
                               input bit expectResp);
    sb_t e;
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    acceptCyc = cyc;
    if (expectResp) begin
      e.data = expData;
      e.err  = expErr;
      e.lat  = expLat;
      sbQ.push_back(e);
    end
    stepCycle();
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 16'hFFFF;
    req_data  = 16'hFFFF;
  endtask

  // Plays the memory for one access: waits+1 cycles of strobe, optionally
  // acking in the last one. Called in the first cycle of the access.
  task automatic serveAccess(input string tag, input logic [1:0] expMs,
                             input logic expWe, input logic [15:0] expAddr,
                             input logic [15:0] expDin, input int waits,
                             input logic [15:0] dout, input bit giveAck);
    for (int i = 0; i <= waits; i++) begin
      checkOutput({tag, "_en"}, dmem_en, 1);
      checkOutput({tag, "_we"}, dmem_we, expWe);
      checkOutput({tag, "_addr"}, dmem_addr, expAddr);
      checkOutput({tag, "_mem_state"}, mem_state, expMs);
      checkOutput({tag, "_resp_valid"}, resp_valid, 0);
      if (expWe) checkOutput({tag, "_din"}, dmem_din, expDin);
      if (i == waits && giveAck) begin
        dmem_ack  = 1'b1;
        dmem_dout = dout;
      end
      stepCycle();
      dmem_ack  = 1'b0;
      dmem_dout = 16'h5555;
    end
  endtask

  // Waits (bounded) for resp_valid and compares it with the queued entry.
  task automatic expectResponse(input string tag);
    sb_t e;
    int  n;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_resp_valid"}, resp_valid, 1);
    checks++;
    assert (sbQ.size() > 0) else begin
      failures++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_resp_data"}, resp_data, e.data);
      checkOutput({tag, "_resp_err"}, resp_err, e.err);
      checkOutput({tag, "_latency"}, cyc - acceptCyc, e.lat);
    end
    checkOutput({tag, "_resp_en"}, dmem_en, 0);
    checkOutput({tag, "_resp_mem_state"}, mem_state, MS_IDLE);
    checkOutput({tag, "_resp_ready"}, req_ready, 0);
    stepCycle();
    checkOutput({tag, "_post_valid"}, resp_valid, 0);
    checkOutput({tag, "_post_err"}, resp_err, 0);
    checkOutput({tag, "_post_ready"}, req_ready, 1);
    checkOutput({tag, "_post_en"}, dmem_en, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    acceptCyc = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 16'h0000;
    req_data  = 16'h0000;
    dmem_ack  = 1'b0;
    dmem_dout = 16'h0000;

    #2;
    checkResetValues("rst0");
    stepCycle();
    stepCycle();
    reset = 1'b1;
    stepCycle();
    checkResetValues("rst_rel");

    // Ack while no access is in flight must be ignored.
    dmem_ack  = 1'b1;
    dmem_dout = 16'hDEAD;
    stepCycle();
    dmem_ack  = 1'b0;
    checkOutput("stray_ack_state", mem_state, MS_IDLE);
    checkOutput("stray_ack_valid", resp_valid, 0);
    checkOutput("stray_ack_data", resp_data, 0);
    checkOutput("stray_ack_en", dmem_en, 0);

    // Zero-wait READ.
    applyStimulus(OP_READ, 16'h3000, 16'h0000, 16'hBEEF, 1'b0, 2, 1'b1);
    serveAccess("t1_rd", MS_READ, 1'b0, 16'h3000, 16'h0000, 0, 16'hBEEF, 1'b1);
    expectResponse("t1");

    // Zero-wait WRITE_IND through pointer 0x4000; resp_data unchanged.
    applyStimulus(OP_WRITE_IND, 16'h0010, 16'h1234, 16'hBEEF, 1'b0, 3, 1'b1);
    serveAccess("t2_ind", MS_IND, 1'b0, 16'h0010, 16'h0000, 0, 16'h4000, 1'b1);
    serveAccess("t2_wr", MS_WRITE, 1'b1, 16'h4000, 16'h1234, 0, 16'h0000, 1'b1);
    expectResponse("t2");

    // READ with three wait cycles.
    applyStimulus(OP_READ, 16'h0222, 16'h0000, 16'h5A5A, 1'b0, 5, 1'b1);
    serveAccess("t3_rd", MS_READ, 1'b0, 16'h0222, 16'h0000, 3, 16'h5A5A, 1'b1);
    expectResponse("t3");

    // READ_IND with no ack: times out in IND, no RD access.
    applyStimulus(OP_READ_IND, 16'h0100, 16'h0000, 16'h5A5A, 1'b1, 17, 1'b1);
    serveAccess("t4_ind", MS_IND, 1'b0, 16'h0100, 16'h0000, 15, 16'h0000, 1'b0);
    expectResponse("t4");

    // Ack in the same cycle the counter reaches TIMEOUT: ack wins.
    applyStimulus(OP_READ, 16'h0777, 16'h0000, 16'hC0DE, 1'b0, 17, 1'b1);
    serveAccess("t5_rd", MS_READ, 1'b0, 16'h0777, 16'h0000, 15, 16'hC0DE, 1'b1);
    expectResponse("t5");

    // WRITE with two waits; load data must stay put.
    applyStimulus(OP_WRITE, 16'h0ABC, 16'h9876, 16'hC0DE, 1'b0, 4, 1'b1);
    serveAccess("t6_wr", MS_WRITE, 1'b1, 16'h0ABC, 16'h9876, 2, 16'h0000, 1'b1);
    expectResponse("t6");

    // READ_IND with waits in both phases; counter restarts for the RD phase.
    applyStimulus(OP_READ_IND, 16'h0020, 16'h0000, 16'h7777, 1'b0, 6, 1'b1);
    serveAccess("t7_ind", MS_IND, 1'b0, 16'h0020, 16'h0000, 1, 16'h0300, 1'b1);
    serveAccess("t7_rd", MS_READ, 1'b0, 16'h0300, 16'h0000, 2, 16'h7777, 1'b1);
    expectResponse("t7");

    // Reset in the middle of a WR wait abandons the op.
    applyStimulus(OP_WRITE, 16'h0555, 16'hAAAA, 16'h0000, 1'b0, 0, 1'b0);
    serveAccess("t8_wr", MS_WRITE, 1'b1, 16'h0555, 16'hAAAA, 1, 16'h0000, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkResetValues("t8_midrst");
    stepCycle();
    stepCycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("t8_no_resp", resp_valid, 0);
      checkOutput("t8_idle", mem_state, MS_IDLE);
    end

    // First request after reset release completes normally.
    applyStimulus(OP_READ, 16'h0042, 16'h0000, 16'h1111, 1'b0, 2, 1'b1);
    serveAccess("t9_rd", MS_READ, 1'b0, 16'h0042, 16'h0000, 0, 16'h1111, 1'b1);
    expectResponse("t9");

    checkOutput("sb_drained", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
